// File: rtl/ld_st_buffer_pkg.sv
// ld_st_buffer_pkg: shared types and constants for the load/store buffer.
//   ROBEN_W / XLEN : ROB tag width and datapath width
//   TAG_READY      : tag value meaning "operand already valid"
//   lsb_entry_t    : one buffer slot
//   lsb_snoop()    : applies a CDB broadcast to an entry's pending tags
package ld_st_buffer_pkg;

    localparam int ROBEN_W = 5;
    localparam int XLEN    = 32;

    localparam logic [ROBEN_W-1:0] TAG_READY = '0;

    typedef struct packed {
        logic               busy;
        logic               is_store;
        logic [ROBEN_W-1:0] roben;
        logic [ROBEN_W-1:0] base_tag;
        logic [XLEN-1:0]    base_val;
        logic [ROBEN_W-1:0] data_tag;
        logic [XLEN-1:0]    data_val;
        logic [XLEN-1:0]    imm;
    } lsb_entry_t;

    // Capture a matching CDB value into each still-pending operand.
    // TAG_READY never matches, so a valid operand is never overwritten.
    function automatic lsb_entry_t lsb_snoop(input lsb_entry_t         e,
                                             input logic               cdb_valid,
                                             input logic [ROBEN_W-1:0] cdb_roben,
                                             input logic [XLEN-1:0]    cdb_value);
        lsb_entry_t r;
        r = e;
        if (cdb_valid && e.base_tag != TAG_READY && e.base_tag == cdb_roben) begin
            r.base_tag = TAG_READY;
            r.base_val = cdb_value;
        end
        if (cdb_valid && e.data_tag != TAG_READY && e.data_tag == cdb_roben) begin
            r.data_tag = TAG_READY;
            r.data_val = cdb_value;
        end
        return r;
    endfunction

endpackage

// File: rtl/ld_st_buffer_entry.sv
// lsb_entry: one load/store buffer slot with CDB wakeup.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : flush, clears the slot (highest priority)
//   wr_en      : write wr_data into the slot (alloc); CDB bypass applied on write
//   pop        : slot issued, drop busy
//   cdb_*      : common data bus snoop
//   entry_o    : current slot contents
module lsb_entry
    import ld_st_buffer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               wr_en,
    input  lsb_entry_t         wr_data,
    input  logic               pop,
    input  logic               cdb_valid,
    input  logic [ROBEN_W-1:0] cdb_roben,
    input  logic [XLEN-1:0]    cdb_value,
    output lsb_entry_t         entry_o
);

    lsb_entry_t entry_q, entry_d;

    always_comb begin
        entry_d = entry_q;
        if (entry_q.busy)
            entry_d = lsb_snoop(entry_q, cdb_valid, cdb_roben, cdb_value);
        if (pop)
            entry_d.busy = 1'b0;
        // Alloc in the same cycle as a matching broadcast captures it directly.
        if (wr_en)
            entry_d = lsb_snoop(wr_data, cdb_valid, cdb_roben, cdb_value);
        if (clr)
            entry_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) entry_q <= '0;
        else     entry_q <= entry_d;
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/ld_st_buffer.sv
// ld_st_buffer: in-order load/store buffer feeding the data memory stage.
// Ops enter at tail, wake from the CDB, and only the head may issue; stores
// wait until they are at the ROB head. One registered request per cycle.
//   clk, rst            : clock, synchronous active-high reset
//   alloc_*             : new op from dispatch (dropped while full)
//   full                : no alloc accepted this cycle
//   cdb_*               : common data bus snoop
//   rob_head_roben      : ROB head tag, gates store issue
//   flush               : squash everything
//   mem_*               : registered data memory request
// Optional: define LSB_STATS_EN to add stat_loads / stat_stores issue counters.
module ld_st_buffer
    import ld_st_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_valid,
    input  logic               alloc_is_store,
    input  logic [ROBEN_W-1:0] alloc_roben,
    input  logic [ROBEN_W-1:0] alloc_base_tag,
    input  logic [XLEN-1:0]    alloc_base_val,
    input  logic [ROBEN_W-1:0] alloc_data_tag,
    input  logic [XLEN-1:0]    alloc_data_val,
    input  logic [XLEN-1:0]    alloc_imm,
    output logic               full,
    input  logic               cdb_valid,
    input  logic [ROBEN_W-1:0] cdb_roben,
    input  logic [XLEN-1:0]    cdb_value,
    input  logic [ROBEN_W-1:0] rob_head_roben,
    input  logic               flush,
`ifdef LSB_STATS_EN
    output logic [31:0]        stat_loads,
    output logic [31:0]        stat_stores,
`endif
    output logic [ROBEN_W-1:0] mem_roben,
    output logic               mem_read_en,
    output logic               mem_write_en,
    output logic [XLEN-1:0]    mem_address,
    output logic [XLEN-1:0]    mem_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    lsb_entry_t       ent [DEPTH];
    lsb_entry_t       alloc_ent;
    lsb_entry_t       hd;
    logic             do_alloc, hd_ready, issue;
    logic [XLEN-1:0]  addr;

    logic [ROBEN_W-1:0] mem_roben_q;
    logic               mem_read_en_q, mem_write_en_q;
    logic [XLEN-1:0]    mem_address_q, mem_data_q;

    // Registered count, so an issue this cycle never frees a slot for this
    // cycle's alloc.
    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign do_alloc = alloc_valid && !full;

    always_comb begin
        alloc_ent          = '0;
        alloc_ent.busy     = 1'b1;
        alloc_ent.is_store = alloc_is_store;
        alloc_ent.roben    = alloc_roben;
        alloc_ent.base_tag = alloc_base_tag;
        alloc_ent.base_val = alloc_base_val;
        alloc_ent.data_tag = alloc_data_tag;
        alloc_ent.data_val = alloc_data_val;
        alloc_ent.imm      = alloc_imm;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        lsb_entry u_ent (
            .clk       (clk),
            .rst       (rst),
            .clr       (flush),
            .wr_en     (do_alloc && (tail_q == PTR_W'(g))),
            .wr_data   (alloc_ent),
            .pop       (issue && (head_q == PTR_W'(g))),
            .cdb_valid (cdb_valid),
            .cdb_roben (cdb_roben),
            .cdb_value (cdb_value),
            .entry_o   (ent[g])
        );
    end

    // Head-only issue: a blocked head stalls every younger op.
    always_comb begin
        hd = ent[head_q];
        if (hd.is_store)
            hd_ready = (hd.base_tag == TAG_READY) && (hd.data_tag == TAG_READY)
                       && (hd.roben == rob_head_roben);
        else
            hd_ready = (hd.base_tag == TAG_READY);
        issue = hd.busy && hd_ready && !flush;
    end

    assign addr = hd.base_val + hd.imm;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + {{PTR_W{1'b0}}, do_alloc} - {{PTR_W{1'b0}}, issue};
        if (do_alloc) tail_d = tail_q + 1'b1;
        if (issue)    head_d = head_q + 1'b1;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Request registers: enables pulse for one cycle, payload holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_roben_q    <= '0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            mem_address_q  <= '0;
            mem_data_q     <= '0;
        end else begin
            mem_read_en_q  <= issue && !hd.is_store;
            mem_write_en_q <= issue && hd.is_store;
            if (issue) begin
                mem_roben_q   <= hd.roben;
                mem_address_q <= addr;
                mem_data_q    <= hd.is_store ? hd.data_val : '0;
            end
        end
    end

    assign mem_roben    = mem_roben_q;
    assign mem_read_en  = mem_read_en_q;
    assign mem_write_en = mem_write_en_q;
    assign mem_address  = mem_address_q;
    assign mem_data     = mem_data_q;

`ifdef LSB_STATS_EN
    // Survive flush; only reset clears them.
    logic [31:0] stat_loads_q, stat_stores_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_loads_q  <= '0;
            stat_stores_q <= '0;
        end else if (issue) begin
            if (hd.is_store) stat_stores_q <= stat_stores_q + 32'd1;
            else             stat_loads_q  <= stat_loads_q + 32'd1;
        end
    end

    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
`endif

endmodule
